// File: rtl/kuz_pkg.sv
// -----------------------------------------------------------------------------
// kuz_pkg
// Shared constants and helpers for the Kuznyechik linear layer:
//   GF_POLY  - low byte of the field reduction polynomial x^8+x^7+x^6+x+1
//   L_COEF   - coefficients of the linear function l, entry 0 multiplies a15
//   gf_mul8  - GF(2^8) multiply in that field
//   conv_state_t - control states of the iterative L transform
// -----------------------------------------------------------------------------
package kuz_pkg;

   localparam logic [7:0] GF_POLY = 8'hC3;

   localparam logic [7:0] L_COEF [16] = '{
      8'd148, 8'd32,  8'd133, 8'd16,  8'd194, 8'd192, 8'd1,   8'd251,
      8'd1,   8'd192, 8'd194, 8'd16,  8'd133, 8'd32,  8'd148, 8'd1
   };

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } conv_state_t;

   // Shift-and-add multiply: walk the bits of b, doubling a (with reduction)
   // at each step and accumulating the doubled value where b has a one.
   function automatic logic [7:0] gf_mul8(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] prod;
      logic [7:0] x;
      prod = '0;
      x    = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) prod = prod ^ x;
         x = x[7] ? ((x << 1) ^ GF_POLY) : (x << 1);
      end
      return prod;
   endfunction

endpackage

// File: rtl/kuz_r_step.sv
// -----------------------------------------------------------------------------
// kuz_r_step
// Combinational R step of the Kuznyechik linear layer:
//   R(a) = {l(a), a[127:8]}
// Ports:
//   data_in  [127:0]  block a, byte a15 at [127:120], a0 at [7:0]
//   data_out [127:0]  R(a)
// -----------------------------------------------------------------------------
module kuz_r_step
   import kuz_pkg::*;
(
   input  logic [127:0] data_in,
   output logic [127:0] data_out
);

   logic [7:0] l_byte;

   always_comb begin
      // NOTE: combinational logic uses blocking assignments so the running
      // XOR accumulates in order within one evaluation; registers elsewhere
      // use non-blocking.
      l_byte = '0;
      for (int i = 0; i < 16; i++) begin
         l_byte = l_byte ^ gf_mul8(L_COEF[i], data_in[127 - 8*i -: 8]);
      end
   end

   assign data_out = {l_byte, data_in[127:8]};

endmodule

// File: rtl/l_conversion.sv
// -----------------------------------------------------------------------------
// l_conversion
// Iterative Kuznyechik L transform: sixteen R steps, one per clock.
// Ports:
//   clk                rising-edge clock
//   rst                synchronous active-high reset
//   enable             request level, held high for the whole conversion
//   input_word [127:0] block to transform, sampled on the start edge only
//   output_word[127:0] registered result, updated only on completion/reset
//   finish_convertion  high while the result is being presented (DONE)
// Dropping enable mid-run aborts; after DONE, enable must go low for one edge
// before a new conversion can start.
// -----------------------------------------------------------------------------
module l_conversion
   import kuz_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         enable,
   input  logic [127:0] input_word,
   output logic [127:0] output_word,
   output logic         finish_convertion
);

   conv_state_t  state_q, state_d;
   logic [3:0]   cnt_q, cnt_d;
   logic [127:0] work_q, work_d;
   logic [127:0] out_q, out_d;
   logic         fin_q, fin_d;
   logic [127:0] r_out;

   kuz_r_step u_r_step (
      .data_in  (work_q),
      .data_out (r_out)
   );

   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves
      // it unassigned, which would otherwise infer a latch.
      state_d = state_q;
      cnt_d   = cnt_q;
      work_d  = work_q;
      out_d   = out_q;
      fin_d   = fin_q;

      unique case (state_q)
         IDLE: begin
            if (enable) begin
               work_d  = input_word;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            if (!enable) begin
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               work_d = r_out;
               cnt_d  = cnt_q + 4'd1;
               if (cnt_q == 4'd15) begin
                  out_d   = r_out;
                  fin_d   = 1'b1;
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            // Result is held until enable drops; no auto-restart.
            if (!enable) begin
               fin_d   = 1'b0;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values, independent of statement order.
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         work_q  <= '0;
         out_q   <= '0;
         fin_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         work_q  <= work_d;
         out_q   <= out_d;
         fin_q   <= fin_d;
      end
   end

   assign output_word       = out_q;
   assign finish_convertion = fin_q;

endmodule

// File: tb/tb_l_conversion.sv
// -----------------------------------------------------------------------------
// tb_l_conversion
// Directed bench for l_conversion and kuz_r_step. Expected L results are
// queued when a conversion is launched and popped when finish_convertion rises.
// -----------------------------------------------------------------------------
module tb_l_conversion;
   import kuz_pkg::*;

   logic         clk = 1'b0;
   logic         rst;
   logic         enable;
   logic [127:0] input_word;
   logic [127:0] output_word;
   logic         finish_convertion;

   logic [127:0] r_in;
   logic [127:0] r_out;

   logic [127:0] exp_q [$];
   int errors = 0;
   int checks = 0;

   localparam logic [127:0] V0 = 128'h64a59400000000000000000000000000;
   localparam logic [127:0] V1 = 128'hd456584dd0e3e84cc3166e4b7fa2890d;
   localparam logic [127:0] V2 = 128'h79d26221b87b584cd42fbc4ffea5de9a;
   localparam logic [127:0] V3 = 128'h0e93691a0cfc60408b7b68f66b513c13;

   l_conversion dut (
      .clk               (clk),
      .rst               (rst),
      .enable            (enable),
      .input_word        (input_word),
      .output_word       (output_word),
      .finish_convertion (finish_convertion)
   );

   kuz_r_step u_r (
      .data_in  (r_in),
      .data_out (r_out)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [127:0] observed,
                        input logic [127:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Advance n rising edges and settle 1 time unit past the last one.
   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Launch one conversion, keep enable high, wait (bounded) for finish,
   // then compare latency and the popped expected result.
   task automatic run_l(input string tag, input logic [127:0] din,
                        input logic [127:0] expected);
      int edges;
      logic [127:0] want;
      exp_q.push_back(expected);
      input_word = din;
      enable     = 1'b1;
      tick();                       // sampling edge
      edges = 1;
      while (!finish_convertion && edges < 40) begin
         tick();
         edges++;
      end
      check({tag, " latency"}, 128'(edges), 128'd17);
      check({tag, " finish"}, 128'(finish_convertion), 128'd1);
      want = exp_q.pop_front();
      check({tag, " result"}, output_word, want);
   endtask

   task automatic drop_enable(input string tag, input logic [127:0] held);
      enable = 1'b0;
      tick();
      check({tag, " finish low"}, 128'(finish_convertion), 128'd0);
      check({tag, " output kept"}, output_word, held);
   endtask

   initial begin
      rst        = 1'b1;
      enable     = 1'b1;                // reset must override enable
      input_word = V0;
      r_in       = '0;
      tick(2);
      check("reset output", output_word, '0);
      check("reset finish", 128'(finish_convertion), 128'd0);
      check("reset state", 128'(dut.state_q), 128'(IDLE));
      enable = 1'b0;
      rst    = 1'b0;
      tick();

      // Single R step, combinational
      r_in = 128'h00000000000000000000000000000100;
      #1;
      check("r_step 1", r_out, 128'h94000000000000000000000000000001);
      r_in = 128'h94000000000000000000000000000001;
      #1;
      check("r_step 2", r_out, 128'ha5940000000000000000000000000000);

      // Just before round 16 finish must still be low
      input_word = V0;
      enable     = 1'b1;
      tick(16);
      check("pre-finish low", 128'(finish_convertion), 128'd0);
      tick();
      check("finish at edge 17", 128'(finish_convertion), 128'd1);
      check("L(V0) direct", output_word, V1);
      drop_enable("first", V1);
      tick();

      // Zero in, zero out
      run_l("zero", '0, '0);
      drop_enable("zero", '0);
      tick();

      // Full L, then hold enable 50 cycles with a changing input
      run_l("L V0", V0, V1);
      input_word = V3;
      tick(50);
      check("hold finish", 128'(finish_convertion), 128'd1);
      check("hold output", output_word, V1);
      check("no restart", 128'(dut.state_q), 128'(DONE));
      drop_enable("L V0", V1);

      // Chained conversions
      run_l("L V1", V1, V2);
      drop_enable("L V1", V2);
      run_l("L V2", V2, V3);
      drop_enable("L V2", V3);

      // Abort after 8 rounds
      input_word = V0;
      enable     = 1'b1;
      tick();                        // load
      tick(8);                       // rounds 1..8
      enable = 1'b0;
      tick();
      check("abort finish", 128'(finish_convertion), 128'd0);
      check("abort output", output_word, V3);
      check("abort state", 128'(dut.state_q), 128'(IDLE));
      tick(20);
      check("abort finish stays", 128'(finish_convertion), 128'd0);
      check("abort output stays", output_word, V3);
      run_l("after abort", V0, V1);
      drop_enable("after abort", V1);

      // Reset mid-run
      input_word = V2;
      enable     = 1'b1;
      tick(6);
      rst = 1'b1;
      tick();
      check("midrun rst output", output_word, '0);
      check("midrun rst finish", 128'(finish_convertion), 128'd0);
      check("midrun rst state", 128'(dut.state_q), 128'(IDLE));
      rst    = 1'b0;
      enable = 1'b0;
      tick();
      run_l("after rst", V1, V2);
      drop_enable("after rst", V2);

      check("queue drained", 128'(exp_q.size()), 128'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/l_conversion.md
Name: l_conversion

Overview:
- Iterative linear transform L of the Kuznyechik (GOST R 34.12-2015) block cipher, operating on one 128-bit block.
- L is 16 applications of the byte-shift/LFSR step R over GF(2^8).
- Sits in the encryption round datapath after the S-box layer, and in the key schedule.
- Computes one R step per clock under a level-sensitive enable/finish handshake.

Parameters:
- None. All constants are fixed by the standard and live in the shared package.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  request level; held high for the whole conversion.
- input_word  input  128  block to transform. Byte a15 = [127:120], a0 = [7:0].
- output_word  output  128  transformed block, registered.
- finish_convertion  output  1  result valid; high while in DONE.

Behaviour:
- GF(2^8) field: reduction polynomial x^8+x^7+x^6+x+1 (0x1C3).
- l(a15..a0) = 148·a15 ^ 32·a14 ^ 133·a13 ^ 16·a12 ^ 194·a11 ^ 192·a10 ^ 1·a9 ^ 251·a8 ^ 1·a7 ^ 192·a6 ^ 194·a5 ^ 16·a4 ^ 133·a3 ^ 32·a2 ^ 148·a1 ^ 1·a0.
- R(a) = {l(a), a[127:8]}: shift right one byte, with l inserted at bits [127:120].
- L(a) = R applied 16 times.
- FSM states: IDLE, RUN, DONE. Internal registers: 128-bit state, 4-bit round counter.
- Reset (synchronous, rst=1 at a rising edge):
  - state=IDLE, counter=0, working register=0.
  - output_word=0, finish_convertion=0.
  - rst overrides every other input.
- IDLE, enable=1: latch input_word into the working register, counter=0, go to RUN. input_word is sampled only at this edge.
- RUN: each edge, working register <= R(working register), counter++.
  - On the edge applying round 16 (counter==15): output_word <= R(working register), finish_convertion <= 1, go to DONE.
- Latency: finish_convertion rises 17 clock edges after the edge that sampled enable=1 (1 load + 16 rounds).
- DONE: output_word and finish_convertion held stable while enable=1. input_word changes are ignored.
- DONE, enable=0: go to IDLE, finish_convertion <= 0. output_word keeps the last result.
- A new conversion requires enable to be low for at least one edge after DONE. No auto-restart while enable stays high.
- enable=0 during RUN: abort to IDLE. Counter cleared; output_word and finish_convertion unchanged (finish stays 0).
- output_word changes only at completion or reset.

Decomposition:
- Package kuz_pkg contains:
  - GF_POLY = 8'hC3 (low byte of 0x1C3).
  - 16-entry L coefficient constant array {148,32,133,16,194,192,1,251,1,192,194,16,133,32,148,1}, indexed a15..a0.
  - Function gf_mul8: shift-and-add multiply, reduce by GF_POLY.
  - State enum.
- One natural sub-module: kuz_r_step.
  - Combinational 128→128 R function.
  - Instantiated once in l_conversion.
  - Reusable by the key schedule.

Test Plan:
- kuz_r_step alone:
  - 00000000000000000000000000000100 -> 94000000000000000000000000000001.
  - 94000000000000000000000000000001 -> a5940000000000000000000000000000.
- Full L, enable held high from input load:
  - input 64a59400000000000000000000000000 -> output d456584dd0e3e84cc3166e4b7fa2890d.
  - finish_convertion rises exactly 17 edges after enable sampled.
- Chained L, each with enable low between runs:
  - d456584dd0e3e84cc3166e4b7fa2890d -> 79d26221b87b584cd42fbc4ffea5de9a.
  - 79d26221b87b584cd42fbc4ffea5de9a -> 0e93691a0cfc60408b7b68f66b513c13.
- Zero input -> zero output, finish asserted. Enable held 50 cycles -> finish stays high, no restart. Enable low -> finish low next edge.
- Abort and reset:
  - Drop enable at round 8 -> finish never asserts, output_word unchanged; a new run then produces a correct result.
  - rst pulsed mid-RUN -> output 0, finish 0, state IDLE at the next edge.
